// File: rtl/rf_write_arbiter.sv
// Single write-port owner for the 32x32 regfile: clears r1..r(2^AW-1) after
// reset, then shares the port among NREQ requesters using round-robin valid/ready.
module rf_write_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic                 init_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [PW-1:0]   ptr_q, ptr_d, gidx;
  logic            found;
  logic            we3_q;
  logic [AW-1:0]   wa3_q, sel_addr;
  logic [DW-1:0]   wd3_q, sel_data;

  // Round-robin scan starting at ptr_q; first valid requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = PW'(idx);
      end
    end
    if (hold || state_q != S_RUN) found = 1'b0;
    req_ready = '0;
    if (found) req_ready[gidx] = 1'b1;
    ptr_d    = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    sel_addr = req_addr[gidx*AW +: AW];
    sel_data = req_data[gidx*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      cnt_q   <= AW'(1);
      ptr_q   <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          we3_q <= 1'b1;
          wa3_q <= cnt_q;
          wd3_q <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= S_RUN;
        end
        default: begin
          we3_q <= 1'b0;
          if (found) begin
            ptr_q <= ptr_d;
            // Writes to r0 are accepted but dropped so r0 stays zero.
            if (sel_addr != '0) begin
              we3_q <= 1'b1;
              wa3_q <= sel_addr;
              wd3_q <= sel_data;
            end
          end
        end
      endcase
    end
  end

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign init_busy = (state_q == S_INIT);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected port writes are queued when
// a cycle is driven and compared after the clock edge that produces them.
module tb_rf_write_arbiter;
  localparam int NREQ = 2, AW = 5, DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 hold = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [DW-1:0]        wd3;
  logic                 init_busy;

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Regfile stand-in fed by the write port.
  logic [31:0] rf [32];
  initial rf[0] = 32'h0;
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  typedef struct { logic we; logic [4:0] wa; logic [31:0] wd; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  bit          m_init;
  int          m_cnt, m_ptr;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called in the low phase; returns granted requester index or -1.
  task automatic step(output int g);
    logic [1:0] eg;
    logic [4:0] a;
    exp_t e;
    #1;
    eg = '0;
    g  = -1;
    if (!m_init && !hold)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    if (g >= 0) eg[g] = 1'b1;
    chk("ready", 32'(req_ready), 32'(eg));
    chk("busy", 32'(init_busy), 32'(m_init));
    if (m_init) begin
      q.push_back('{1'b1, m_cnt[4:0], 32'h0});
      if (m_cnt == 31) m_init = 1'b0;
      m_cnt++;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      a = req_addr[g*AW +: AW];
      if (a != 5'd0) q.push_back('{1'b1, a, req_data[g*DW +: DW]});
      else           q.push_back('{1'b0, m_wa, m_wd});
    end else begin
      q.push_back('{1'b0, m_wa, m_wd});
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("we3", 32'(we3), 32'(e.we));
    chk("wa3", 32'(wa3), 32'(e.wa));
    chk("wd3", wd3, e.wd);
    m_wa = e.wa;
    m_wd = e.wd;
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we3", 32'(we3), 32'h0);
    chk("rst_wa3", 32'(wa3), 32'h0);
    chk("rst_wd3", wd3, 32'h0);
    chk("rst_busy", 32'(init_busy), 32'h1);
    chk("rst_ready", 32'(req_ready), 32'h0);
    m_init = 1'b1; m_cnt = 1; m_ptr = 0; m_wa = '0; m_wd = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    // Clear sequence with both requesters pending.
    async_reset();
    req_valid = 2'b11;
    req_addr  = {5'd6, 5'd5};
    req_data  = {32'h66, 32'h55};
    repeat (31) step(g);
    step(g); if (g >= 0) req_valid[g] = 1'b0;
    step(g); if (g >= 0) req_valid[g] = 1'b0;

    // Single write, then read back through the regfile.
    req_valid = 2'b01; req_addr[4:0] = 5'd2; req_data[31:0] = 32'd12;
    step(g); if (g >= 0) req_valid[g] = 1'b0;
    step(g);
    chk("rd_r2", rf[2], 32'd12);

    // Continuous contention alternates.
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = {32'hB, 32'hA};
    repeat (4) step(g);
    req_valid = 2'b00;
    step(g);

    // Write to r0 is accepted but dropped.
    req_valid = 2'b10; req_addr[9:5] = 5'd0; req_data[63:32] = 32'hFFFF_FFFF;
    step(g); if (g >= 0) req_valid[g] = 1'b0;
    step(g);
    chk("rd_r0", rf[0], 32'h0);
    req_valid = 2'b11; req_addr = {5'd9, 5'd8};
    step(g); if (g >= 0) req_valid[g] = 1'b0;
    step(g); if (g >= 0) req_valid[g] = 1'b0;

    // hold blocks grants.
    hold = 1'b1; req_valid = 2'b01; req_addr[4:0] = 5'd7; req_data[31:0] = 32'h77;
    repeat (3) step(g);
    hold = 1'b0;
    step(g); if (g >= 0) req_valid[g] = 1'b0;
    step(g);

    // Random traffic obeying the stable-until-transfer rule.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = 5'($urandom_range(0, 31));
          req_data[i*DW +: DW] = $urandom;
        end
      hold = ($urandom_range(0, 7) == 0);
      step(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    hold = 1'b0; req_valid = '0;
    step(g);

    // Reset mid-clear restarts from r1.
    async_reset();
    repeat (10) step(g);
    chk("mid_wa3", 32'(wa3), 32'd10);
    #2;
    async_reset();
    repeat (31) step(g);
    repeat (2) step(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
